// File: rtl/uart_pkg.sv
// Shared types and constants for the CoreUART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_STOP2,
    S_WAIT_HIGH
  } rx_state_t;

  localparam int         OS_RATE     = 16;
  localparam logic [3:0] OS_MID      = 4'd7;
  localparam logic [3:0] OS_LAST     = 4'(OS_RATE - 1);
  localparam int         ENTRY_FLAGS = 2;

  // FIFO entry is {ferr, perr, data}
  function automatic int entry_width(input int data_width);
    return data_width + ENTRY_FLAGS;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Generic synchronous show-ahead FIFO; the head word is visible without a read,
// and reads as zero while empty.
module uart_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic                     PCLK,
  input  logic                     PRESET,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (level == '0);
  assign full    = (level == (AW + 1)'(DEPTH));
  assign do_rd   = rd_en && !empty;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts the write
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      if (do_wr && !do_rd)      level <= level + 1'b1;
      else if (!do_wr && do_rd) level <= level - 1'b1;
    end
  end

  always_ff @(posedge PCLK) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/coreuart_rx_engine.sv
// UART receive engine: 16x oversampled framer with run-time format, break detect
// and a per-character flagged receive FIFO.
//   state       | meaning
//   S_IDLE      | line idle, looking for a low sample on a tick
//   S_START     | confirming start bit at its midpoint
//   S_DATA      | sampling data bits LSB-first
//   S_PARITY    | sampling parity bit
//   S_STOP      | sampling first stop bit
//   S_STOP2     | sampling second stop bit
//   S_WAIT_HIGH | framing error with line low; wait for line to return high
module coreuart_rx_engine
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int BAUD_WIDTH = 13
) (
  input  logic                          PCLK,
  input  logic                          PRESET,
  input  logic [BAUD_WIDTH-1:0]         baud_val,
  input  logic [3:0]                    data_bits,
  input  logic                          parity_en,
  input  logic                          parity_odd,
  input  logic                          stop2,
  input  logic                          RX,
  input  logic                          rd_en,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          rd_perr,
  output logic                          rd_ferr,
  output logic                          rx_rdy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic                          clr_ovf,
  output logic                          break_det
);
  localparam int         EW     = entry_width(DATA_WIDTH);
  localparam logic [3:0] DW_MAX = 4'(DATA_WIDTH);

  rx_state_t              state, state_nxt;
  logic                   rx_m, rx_s;
  logic [BAUD_WIDTH-1:0]  baud_cnt;
  logic                   tick;
  logic [3:0]             scnt;
  logic [3:0]             bit_idx;
  logic [3:0]             nbits;
  logic [DATA_WIDTH-1:0]  data_r;
  logic                   perr_r, par_bit;
  logic                   scnt_clr, bit_clr, smp_data, smp_par, push, ferr_c;
  logic                   mid_smp, end_smp;
  logic                   fifo_full, fifo_empty, drop;
  logic [EW-1:0]          head;

  assign nbits = (data_bits < 4'd5) ? 4'd5 : (data_bits > DW_MAX) ? DW_MAX : data_bits;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= RX;
      rx_s <= rx_m;
    end
  end

  assign tick = (baud_cnt == '0);

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET)    baud_cnt <= '0;
    else if (tick) baud_cnt <= baud_val;
    else           baud_cnt <= baud_cnt - 1'b1;
  end

  assign mid_smp = tick && (scnt == OS_MID);
  assign end_smp = tick && (scnt == OS_LAST);

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    scnt_clr  = 1'b0;
    bit_clr   = 1'b0;
    smp_data  = 1'b0;
    smp_par   = 1'b0;
    push      = 1'b0;
    ferr_c    = 1'b0;
    break_det = 1'b0;
    case (state)
      S_IDLE: if (tick && !rx_s) begin
        state_nxt = S_START;
        scnt_clr  = 1'b1;
      end
      S_START: if (mid_smp) begin
        if (rx_s) state_nxt = S_IDLE;
        else begin
          state_nxt = S_DATA;
          scnt_clr  = 1'b1;
          bit_clr   = 1'b1;
        end
      end
      S_DATA: if (end_smp) begin
        smp_data = 1'b1;
        if (bit_idx == nbits - 1'b1) state_nxt = parity_en ? S_PARITY : S_STOP;
      end
      S_PARITY: if (end_smp) begin
        smp_par   = 1'b1;
        state_nxt = S_STOP;
      end
      S_STOP, S_STOP2: if (end_smp) begin
        if (state == S_STOP && stop2 && rx_s) state_nxt = S_STOP2;
        else begin
          push      = 1'b1;
          ferr_c    = !rx_s;
          break_det = !rx_s && (data_r == '0) && !par_bit;
          state_nxt = rx_s ? S_IDLE : S_WAIT_HIGH;
        end
      end
      S_WAIT_HIGH: if (rx_s) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET)        scnt <= '0;
    else if (scnt_clr) scnt <= '0;
    else if (tick)     scnt <= scnt + 1'b1;
  end

  // par_bit stays 0 without parity, so the break check needs no parity_en term
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      bit_idx <= '0;
      data_r  <= '0;
      perr_r  <= 1'b0;
      par_bit <= 1'b0;
    end else if (bit_clr) begin
      bit_idx <= '0;
      data_r  <= '0;
      perr_r  <= 1'b0;
      par_bit <= 1'b0;
    end else begin
      if (smp_data) begin
        for (int i = 0; i < DATA_WIDTH; i++)
          if (bit_idx == 4'(i)) data_r[i] <= rx_s;
        bit_idx <= bit_idx + 1'b1;
      end
      if (smp_par) begin
        par_bit <= rx_s;
        perr_r  <= (^data_r) ^ rx_s ^ parity_odd;
      end
    end
  end

  assign drop = push && fifo_full && !rd_en;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET)       overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (clr_ovf) overflow <= 1'b0;
  end

  uart_rx_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .wr_en   (push),
    .wr_data ({ferr_c, perr_r, data_r}),
    .rd_en   (rd_en),
    .rd_data (head),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .level   (fifo_level)
  );

  assign rd_data = head[DATA_WIDTH-1:0];
  assign rd_perr = head[DATA_WIDTH];
  assign rd_ferr = head[DATA_WIDTH+1];
  assign rx_rdy  = !fifo_empty;

endmodule

// File: tb/tb_coreuart_rx_engine.sv
// Scoreboard bench for coreuart_rx_engine at baud_val=0 (16 PCLK per bit).
module tb_coreuart_rx_engine;
  import uart_pkg::*;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int BW    = 13;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int BIT_T = 16;

  logic          PCLK = 1'b0;
  logic          PRESET;
  logic [BW-1:0] baud_val;
  logic [3:0]    data_bits;
  logic          parity_en, parity_odd, stop2, RX, rd_en, clr_ovf;
  logic [DW-1:0] rd_data;
  logic          rd_perr, rd_ferr, rx_rdy, overflow, break_det;
  logic [LW-1:0] fifo_level;

  int            n_checks = 0;
  int            n_errors = 0;
  int            brk_cnt  = 0;
  int            model_lvl = 0;
  bit            model_ovf = 0;
  logic [DW+1:0] exp_q[$];

  always #5 PCLK = ~PCLK;

  coreuart_rx_engine #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH),
    .BAUD_WIDTH (BW)
  ) dut (
    .PCLK       (PCLK),
    .PRESET     (PRESET),
    .baud_val   (baud_val),
    .data_bits  (data_bits),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .stop2      (stop2),
    .RX         (RX),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .rd_perr    (rd_perr),
    .rd_ferr    (rd_ferr),
    .rx_rdy     (rx_rdy),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .clr_ovf    (clr_ovf),
    .break_det  (break_det)
  );

  always @(posedge PCLK) if (break_det === 1'b1) brk_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // FIFO occupancy model decides whether a character lands or is dropped
  task automatic expect_char(input logic [DW-1:0] d, input bit pe, input bit fe);
    if (model_lvl < DEPTH) begin
      exp_q.push_back({fe, pe, d});
      model_lvl++;
    end else begin
      model_ovf = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input int nb, input bit pe,
                            input bit po, input bit flip, input int ns);
    logic [DW-1:0] sh;
    bit            p;
    sh = d;
    p  = (^d) ^ po ^ flip;
    RX = 1'b0;
    repeat (BIT_T) @(negedge PCLK);
    for (int i = 0; i < nb; i++) begin
      RX = sh[0];
      sh = sh >> 1;
      repeat (BIT_T) @(negedge PCLK);
    end
    if (pe) begin
      RX = p;
      repeat (BIT_T) @(negedge PCLK);
    end
    RX = 1'b1;
    repeat (ns * BIT_T) @(negedge PCLK);
  endtask

  task automatic send_char(input logic [DW-1:0] d, input int nb, input bit pe,
                           input bit po, input bit flip, input int ns);
    send_frame(d, nb, pe, po, flip, ns);
    expect_char(d, pe && flip, 1'b0);
    repeat (4) @(negedge PCLK);
  endtask

  task automatic drain_one(input string tag);
    int            w;
    logic [DW+1:0] e;
    w = 0;
    while (!rx_rdy && w < 400) begin
      @(negedge PCLK);
      w++;
    end
    check({tag, "_rdy"}, 32'(rx_rdy), 32'd1);
    check({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({tag, "_head"}, 32'({rd_ferr, rd_perr, rd_data}), 32'(e));
    end
    rd_en = 1'b1;
    @(negedge PCLK);
    rd_en = 1'b0;
    if (model_lvl > 0) model_lvl--;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int            cyc;
    int            b0;
    logic [DW+1:0] e;

    PRESET = 1'b1; RX = 1'b1; rd_en = 1'b0; clr_ovf = 1'b0; baud_val = '0;
    data_bits = 4'd8; parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b0;
    repeat (3) @(negedge PCLK);
    check("rst_rx_rdy", 32'(rx_rdy), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_break", 32'(break_det), 32'd0);
    PRESET = 1'b0;
    repeat (4) @(negedge PCLK);

    // 8N1 0xA5 with latency measured from the RX falling edge
    cyc = 0;
    fork
      send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1);
      begin
        while (!rx_rdy && cyc < 200) begin
          @(negedge PCLK);
          cyc++;
        end
      end
    join
    check("a5_latency_in_window", 32'(cyc >= 152 && cyc <= 156), 32'd1);
    expect_char(8'hA5, 1'b0, 1'b0);
    drain_one("a5");
    check("a5_empty_after_pop", 32'(rx_rdy), 32'd0);

    // 7 data bits, odd parity, two stop bits
    data_bits = 4'd7; parity_en = 1'b1; parity_odd = 1'b1; stop2 = 1'b1;
    repeat (4) @(negedge PCLK);
    send_char(8'h41, 7, 1'b1, 1'b1, 1'b0, 2);
    send_char(8'h41, 7, 1'b1, 1'b1, 1'b1, 2);
    check("7o2_level", 32'(fifo_level), 32'd2);
    drain_one("7o2_good");
    drain_one("7o2_bad");

    // data_bits clamping at both ends
    parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b0; data_bits = 4'd2;
    repeat (4) @(negedge PCLK);
    send_char(8'h15, 5, 1'b0, 1'b0, 1'b0, 1);
    drain_one("clamp_lo");
    data_bits = 4'hF;
    repeat (4) @(negedge PCLK);
    send_char(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1);
    drain_one("clamp_hi");
    data_bits = 4'd8;

    // 8-cycle glitch must be rejected
    RX = 1'b0;
    repeat (8) @(negedge PCLK);
    RX = 1'b1;
    repeat (40) @(negedge PCLK);
    check("glitch_rx_rdy", 32'(rx_rdy), 32'd0);
    check("glitch_level", 32'(fifo_level), 32'd0);
    check("glitch_idle", 32'(dut.state), 32'(S_IDLE));

    // break: line low for three frame times
    b0 = brk_cnt;
    RX = 1'b0;
    repeat (480) @(negedge PCLK);
    check("brk_single_push", 32'(fifo_level), 32'd1);
    check("brk_pulse_count", 32'(brk_cnt - b0), 32'd1);
    expect_char(8'h00, 1'b0, 1'b1);
    RX = 1'b1;
    repeat (40) @(negedge PCLK);
    check("brk_no_more_push", 32'(fifo_level), 32'd1);
    drain_one("brk");
    send_char(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1);
    drain_one("after_brk");

    // overflow: five characters into a four-entry FIFO
    for (int i = 0; i < 5; i++) send_char(8'(8'h11 + i), 8, 1'b0, 1'b0, 1'b0, 1);
    check("ovf_level", 32'(fifo_level), 32'(model_lvl));
    check("ovf_flag", 32'(overflow), 32'(model_ovf));
    for (int i = 0; i < 4; i++) drain_one("ovf_drain");
    clr_ovf = 1'b1;
    @(negedge PCLK);
    clr_ovf = 1'b0;
    model_ovf = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'd0);

    // full FIFO: push and pop in the same cycle
    for (int i = 0; i < 4; i++) send_char(8'(8'h21 + i), 8, 1'b0, 1'b0, 1'b0, 1);
    check("full_level", 32'(fifo_level), 32'd4);
    fork
      send_frame(8'h25, 8, 1'b0, 1'b0, 1'b0, 1);
      begin
        repeat (154) @(negedge PCLK);
        check("pp_sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("pp_head", 32'({rd_ferr, rd_perr, rd_data}), 32'(e));
        end
        model_lvl--;
        rd_en = 1'b1;
        @(negedge PCLK);
        rd_en = 1'b0;
      end
    join
    expect_char(8'h25, 1'b0, 1'b0);
    repeat (4) @(negedge PCLK);
    check("pp_level", 32'(fifo_level), 32'(model_lvl));
    check("pp_overflow", 32'(overflow), 32'(model_ovf));
    for (int i = 0; i < 4; i++) drain_one("pp_drain");

    // reset in the middle of a data field with one entry waiting
    send_char(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1);
    RX = 1'b0;
    repeat (BIT_T) @(negedge PCLK);
    RX = 1'b1;
    repeat (BIT_T) @(negedge PCLK);
    RX = 1'b0;
    repeat (BIT_T + 5) @(negedge PCLK);
    PRESET = 1'b1;
    RX = 1'b1;
    exp_q.delete();
    model_lvl = 0;
    repeat (2) @(negedge PCLK);
    check("midrst_level", 32'(fifo_level), 32'd0);
    PRESET = 1'b0;
    repeat (40) @(negedge PCLK);
    send_char(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1);
    check("midrst_one_entry", 32'(fifo_level), 32'd1);
    drain_one("midrst");

    check("final_sb_empty", 32'(exp_q.size()), 32'd0);
    check("final_brk_total", 32'(brk_cnt), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/coreuart_rx_engine.md
# coreuart_rx_engine

Parametrised UART receive engine: the next-generation receive path for the CoreUARTapb family. It recovers asynchronous serial frames with run-time data width, parity mode and stop-bit count, and detects break conditions. Each received character is stored with its own per-character error flags in a show-ahead FIFO. It sits between the RX pad and the APB register block, which drains the FIFO and owns the control fields.

## Interface
Parameters:
- DATA_WIDTH, 8: maximum data bits per frame. Legal range 5..9.
- FIFO_DEPTH, 16: receive FIFO entries. Power of two, 2..256.
- BAUD_WIDTH, 13: width of the baud divisor.

Ports:
- PCLK  in  1  sole clock.
- PRESET  in  1  reset, asynchronous, active-high.
- baud_val  in  BAUD_WIDTH  divisor. The 16x oversample tick fires every baud_val+1 PCLK.
- data_bits  in  4  data bits per frame, 5..DATA_WIDTH. Values outside the range are clamped to the range.
- parity_en  in  1  a parity bit follows the data bits.
- parity_odd  in  1  1 = odd parity, 0 = even parity.
- stop2  in  1  two stop bits expected.
- RX  in  1  asynchronous serial input; idles high.
- rd_en  in  1  pops the FIFO head.
- rd_data  out  DATA_WIDTH  FIFO head data, right-justified, unused upper bits zero.
- rd_perr  out  1  parity error flag of the FIFO head.
- rd_ferr  out  1  framing error flag of the FIFO head.
- rx_rdy  out  1  FIFO not empty.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- overflow  out  1  sticky flag: a character was dropped.
- clr_ovf  in  1  clears overflow.
- break_det  out  1  one-cycle pulse when a break is detected.

## Operation
- RX input: passes through a 2-flop synchroniser (both flops reset to 1) to give rx_s.
- Baud counter: loads baud_val, decrements on every PCLK, and emits tick and reloads when it reaches 0. With baud_val=0, tick is high on every cycle.
- Sample counter: scnt, 4 bits, advances on each tick.
- FSM states: IDLE, START, DATA, PARITY, STOP, STOP2, WAIT_HIGH.
  - IDLE: rx_s=0 on a tick → START, scnt=0.
  - START: at scnt=7, if rx_s=1 → IDLE (glitch rejected). Otherwise scnt=0, bit index=0 → DATA.
  - DATA: sample at each scnt=15 and shift LSB-first. After data_bits samples → PARITY if parity_en, else STOP.
  - PARITY: sample at scnt=15. perr = XOR(data, parity bit, parity_odd) != 0.
  - STOP: sample at scnt=15. ferr = (sample==0). If stop2 and the first stop bit was 1 → STOP2, else the frame completes.
  - STOP2: sample at scnt=15; ferr = (sample==0). The frame completes.
- Frame completion:
  - Push {ferr, perr, data}.
  - Break check: data all zero, parity bit 0 (when present) and ferr=1 → pulse break_det in the same cycle as the push.
  - If ferr=1 and rx_s=0 → WAIT_HIGH, else → IDLE.
- WAIT_HIGH: stay until rx_s=1, then → IDLE. No new start bit is accepted while in this state.
- FIFO, show-ahead:
  - rd_data, rd_perr and rd_ferr always show the head entry.
  - rd_en while empty is ignored.
  - Push while full with no pop: the character is dropped and overflow is set.
  - Push and pop in the same cycle while full: both succeed, overflow is not set.
  - Pointers wrap modulo FIFO_DEPTH.
- Overflow register: clr_ovf clears it. If clr_ovf and a new overflow occur in the same cycle, set wins.
- Control inputs (data_bits, parity_en, parity_odd, stop2) are sampled continuously. Software changes them only while idle.

## Timing
- Reset values: all outputs 0, except rd_data 0 and fifo_level 0; FSM in IDLE; synchroniser at 1; baud counter at 0.
- Reset mid-frame: the partial character is discarded and the FIFO is emptied.
- Latency: the push occurs on the tick of the final stop-bit sample. rx_rdy and fifo_level update on the next PCLK edge.
- rd_en pop: rd_data shows the next entry one cycle after the rd_en edge.
- baud_val=0, 8N1: the push happens 154±2 PCLK after the RX falling edge.

## Structure
- Package uart_pkg holds:
  - the FSM state enum;
  - the FIFO entry width constant (DATA_WIDTH+2);
  - the oversample constants (16, midpoint 7).
- Sub-module uart_rx_fifo: a generic synchronous show-ahead FIFO, parametrised by width and depth, with level output. The framer FSM and baud logic stay in the top level.

## Test plan
- baud_val=0, 8N1, send 0xA5 → rx_rdy within 156 PCLK; rd_data=0xA5, perr=0, ferr=0; rd_en → rx_rdy=0.
- data_bits=7, odd parity, stop2=1: send 0x41 with a correct parity bit, then 0x41 with a flipped parity bit → entries (0x41, perr=0) then (0x41, perr=1).
- 8-cycle low glitch on RX with baud_val=0 → no push, FSM back in IDLE, rx_rdy stays 0.
- RX held low for 3 frame times, 8N1 → exactly one entry 0x00 with ferr=1; one break_det pulse; no further pushes until RX returns high; the next frame is received normally.
- FIFO_DEPTH=4: send 5 characters without reading → fifo_level=4, overflow=1, entries are the first 4. Fill to full, then push and pop in the same cycle → level stays 4, overflow unchanged after clr_ovf.
- PRESET asserted mid-DATA, then released, then 0x3C sent → only 0x3C is received; fifo_level=1.
